// File: rtl/prienc_pkg.sv
// prienc_pkg: shared definitions for the prienc_scan request serialiser.
//   state_e  - scan FSM state encoding (IDLE=0, SCAN=1, EMPTY=2)
//   clog2_w  - ceil(log2(n)) width helper, usable in parameter expressions
package prienc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_EMPTY = 2'd2
    } state_e;

    // Smallest r with 2**r >= n.
    function automatic int unsigned clog2_w(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/prienc_pick.sv
// prienc_pick: combinational priority picker over a request vector.
//   vec    - input vector
//   idx    - index of the lowest (MSB_FIRST=0) or highest (MSB_FIRST=1) set bit, 0 if none
//   any    - at least one bit set
//   single - exactly one bit set
module prienc_pick
    import prienc_pkg::*;
#(
    parameter int unsigned N         = 8,
    parameter bit          MSB_FIRST = 1'b0,
    localparam int unsigned W        = clog2_w(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any,
    output logic         single
);

    // Last hit in the loop wins, so loop direction sets the priority.
    always_comb begin
        idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < int'(N); i++) begin
                if (vec[i]) begin
                    idx = W'(i);
                end
            end
        end else begin
            for (int i = int'(N) - 1; i >= 0; i--) begin
                if (vec[i]) begin
                    idx = W'(i);
                end
            end
        end
    end

    assign any    = |vec;
    // Clearing the lowest set bit leaves zero only for a one-hot vector.
    assign single = any && ((vec & (vec - N'(1))) == '0);

endmodule

// File: rtl/prienc_scan.sv
// prienc_scan: captures an N-bit request vector and emits the index of every
// set bit, one beat per accepted cycle, in priority order.
// Optional: define PRIENC_COUNT_EN to add out_count (popcount of the vector).
//   clk, rst              - clock, asynchronous active-high reset
//   in_valid/in_ready     - vector handshake; in_req is the request vector
//   out_valid/out_ready   - beat handshake
//   out_idx               - index of the current request bit
//   out_last              - final beat of the current vector
//   out_none              - captured vector was zero (single empty beat)
//   busy                  - a vector is held
//   out_count             - (PRIENC_COUNT_EN) popcount of the captured vector
module prienc_scan
    import prienc_pkg::*;
#(
    parameter int unsigned N         = 8,
    parameter bit          MSB_FIRST = 1'b0,
    localparam int unsigned W        = clog2_w(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_req,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_last,
    output logic         out_none,
    output logic         busy
`ifdef PRIENC_COUNT_EN
    ,
    output logic [W:0]   out_count
`endif
);

    state_e         state_q, state_d;
    logic [N-1:0]   pending_q, pending_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_idx_q, out_idx_d;
    logic           out_last_q, out_last_d;
    logic           out_none_q, out_none_d;
    logic           busy_q, busy_d;

    logic [W-1:0]   pick_idx;
    logic           pick_any;
    logic           pick_single;

    // Picker looks at the next pending value so beat outputs can be registered.
    prienc_pick #(
        .N         (N),
        .MSB_FIRST (MSB_FIRST)
    ) u_pick (
        .vec    (pending_d),
        .idx    (pick_idx),
        .any    (pick_any),
        .single (pick_single)
    );

    // Next state and pending vector.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    pending_d = in_req;
                    state_d   = (|in_req) ? ST_SCAN : ST_EMPTY;
                end
            end
            ST_SCAN: begin
                if (out_ready) begin
                    if (out_last_q) begin
                        pending_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        pending_d = pending_q & ~(N'(1) << out_idx_q);
                    end
                end
            end
            ST_EMPTY: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                pending_d = '0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // Output values for the cycle after the edge, decoded from next state.
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        out_idx_d   = '0;
        out_last_d  = 1'b0;
        out_none_d  = 1'b0;
        busy_d      = 1'b0;
        unique case (state_d)
            ST_IDLE: begin
                in_ready_d = 1'b1;
            end
            ST_SCAN: begin
                out_valid_d = pick_any;
                out_idx_d   = pick_idx;
                out_last_d  = pick_single;
                busy_d      = 1'b1;
            end
            ST_EMPTY: begin
                out_valid_d = 1'b1;
                out_last_d  = 1'b1;
                out_none_d  = 1'b1;
                busy_d      = 1'b1;
            end
            default: begin
                in_ready_d = 1'b1;
            end
        endcase
    end

    // State, pending vector and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            out_none_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            out_none_q  <= out_none_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign out_none  = out_none_q;
    assign busy      = busy_q;

`ifdef PRIENC_COUNT_EN
    logic [W:0] count_q, count_d;
    logic [W:0] popcount_c;

    // Popcount of the incoming vector.
    always_comb begin
        popcount_c = '0;
        for (int i = 0; i < int'(N); i++) begin
            popcount_c = popcount_c + (W+1)'(in_req[i]);
        end
    end

    // Latched at capture, held for every beat of that vector.
    always_comb begin
        count_d = count_q;
        if (state_q == ST_IDLE && in_valid && in_ready_q) begin
            count_d = popcount_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign out_count = count_q;
`endif

endmodule

// File: doc/prienc_scan.md
Name: prienc_scan

Overview:
- Parametrised successor to the fixed 4-to-2 encoder.
- Captures an N-bit request vector and emits the binary index of every set bit, one per cycle, in priority order.
- Uses valid/ready handshakes on both sides.
- Sits between interrupt/request aggregation logic and a serial consumer, such as a service dispatcher or a log writer.

Parameters:
- N, 8, width of the request vector; must be ≥2.
- MSB_FIRST, 0, scan order: 0 = lowest index first, 1 = highest index first.
- W, $clog2(N), localparam; width of the index output.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request vector on in_req is valid.
- in_ready  output  1  block can accept a vector.
- in_req  input  N  request vector; bit i set = request i present.
- out_valid  output  1  out_idx/out_last/out_none are valid.
- out_ready  input  1  consumer accepts the current beat.
- out_idx  output  W  index of the current request bit.
- out_last  output  1  current beat is the final beat of this vector.
- out_none  output  1  captured vector was all zeros; single empty beat.
- busy  output  1  a vector is held (state != IDLE).

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, pending=0.
  - out_valid=0, out_idx=0, out_last=0, out_none=0, busy=0.
  - in_ready=1 immediately after rst deasserts.
  - rst mid-burst abandons the remaining bits with no further beats.
- States: IDLE, SCAN, EMPTY.
- IDLE:
  - in_ready=1.
  - Capture occurs when in_valid && in_ready: pending<=in_req.
  - Next state is SCAN if in_req!=0, otherwise EMPTY.
  - in_req is ignored when in_valid=0.
- Latency: a vector captured at edge k presents its first beat (out_valid=1) in the cycle after edge k.
- SCAN:
  - out_valid=1, in_ready=0.
  - out_idx = priority pick of pending: lowest set bit if MSB_FIRST=0, highest set bit if MSB_FIRST=1.
  - out_last=1 iff pending has exactly one bit set.
  - On out_valid && out_ready: clear the picked bit in pending.
  - If out_last was 1 at that handshake: pending<=0 and state<=IDLE.
- EMPTY:
  - out_valid=1, out_none=1, out_last=1, out_idx=0.
  - On out_ready: state<=IDLE.
- Back-pressure: while out_valid && !out_ready, out_idx/out_last/out_none hold stable and pending is unchanged.
- No overlap:
  - in_ready=0 in SCAN/EMPTY, so one idle cycle separates the last beat from the next capture.
  - in_ready is decoded from state only and has no combinational path from in_valid/out_ready.
- Beat count:
  - Exactly popcount(in_req) beats for a non-zero vector; exactly 1 beat for zero.
  - All-ones vector gives N beats, 0..N-1 (or N-1..0 when MSB_FIRST=1).
- Outputs are functions of registered state/pending only; they do not change except at clock edges or on rst.
- out_none=0 in SCAN. In IDLE, out_valid=0 and the other outputs are don't-care, but are driven to 0.

Optional Feature:
- PRIENC_COUNT_EN defined:
  - Adds output port out_count [W:0], the popcount of the captured vector.
  - Registered at capture and held constant for every beat of that vector (0 for an empty vector).
  - Reset value 0.
- Not defined: port and counter logic are absent; all other behaviour is identical.

Decomposition:
- Package prienc_pkg:
  - State encoding localparams/typedef (IDLE=2'd0, SCAN=2'd1, EMPTY=2'd2).
  - clog2-style width helper.
- Sub-module prienc_pick (combinational):
  - Parameters N, MSB_FIRST.
  - Input vec [N-1:0]; outputs idx [W-1:0], any, single (exactly one bit set).
  - Instanced once.
- Top holds the FSM, pending register, handshakes and optional counter.

Test Plan:
- N=8, MSB_FIRST=0, in_req=8'b1010_0100, out_ready=1:
  - Beats idx=2,5,7 on consecutive cycles; out_last only on idx=7.
  - in_ready low for 3 cycles, high the cycle after.
- Same vector with MSB_FIRST=1: idx=7,5,2 in that order.
- in_req=8'h00: one beat with out_none=1, out_last=1, idx=0; then IDLE.
- in_req=8'hFF with out_ready toggling 1,0,0,1...:
  - idx holds during stalls.
  - Exactly 8 accepted beats, 0..7; none lost or duplicated.
- rst asserted asynchronously mid-SCAN (after 2 of 4 beats of 8'h0F):
  - out_valid drops without waiting for a clock edge.
  - After rst release, in_ready=1 and a new vector 8'h80 yields a single beat idx=7, out_last=1.
- PRIENC_COUNT_EN build, in_req=8'b0110_1001: out_count=4 on all 4 beats; 0 after reset.
